// File: rtl/mul_datapath_if.sv
// Strobe/result bundle between the multiplier control FSM (master) and the
// repeated-addition datapath (slave).
interface mul_datapath_if #(
    parameter int W  = 8,
    parameter int PW = 16
);
    logic [W-1:0]  data_in;
    logic          ld_a;
    logic          ld_b;
    logic          clr;
    logic          ld_p;
    logic          dec;
    logic          eqz;
    logic [PW-1:0] product;
    logic          ovf;

    modport master (
        output data_in, ld_a, ld_b, clr, ld_p, dec,
        input  eqz, product, ovf
    );

    modport slave (
        input  data_in, ld_a, ld_b, clr, ld_p, dec,
        output eqz, product, ovf
    );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: multiplicand A, down-counting
// multiplier B and product accumulator P with a sticky overflow flag.
// The accumulate strobe is gated by B == 0 so the extra ld_p the FSM issues
// while it observes eqz leaves P untouched.
module mul_datapath #(
    parameter int W  = 8,
    parameter int PW = 16
) (
    input  logic             clk,
    input  logic             rst,
    mul_datapath_if.slave    bus
);
    localparam logic [W-1:0] ONE_W = W'(1);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [PW-1:0] r_p;
    logic          r_ovf;
    logic          w_eqz;
    logic [PW:0]   w_sum;

    assign w_eqz = (r_b == '0);
    // One spare bit holds the carry out of the zero-extended addition.
    assign w_sum = {1'b0, r_p} + {{(PW + 1 - W){1'b0}}, r_a};

    // Multiplicand register: loads from the shared bus, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
        end else if (bus.ld_a) begin
            r_a <= bus.data_in;
        end
    end

    // Multiplier register: load wins over decrement; saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b <= '0;
        end else if (bus.ld_b) begin
            r_b <= bus.data_in;
        end else if (bus.dec && !w_eqz) begin
            r_b <= r_b - ONE_W;
        end
    end

    // Accumulator and sticky overflow: clear wins over accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (bus.clr) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (bus.ld_p && !w_eqz) begin
            r_p <= w_sum[PW-1:0];
            if (w_sum[PW]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.eqz     = w_eqz;
    assign bus.product = r_p;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: a 16-bit-product instance and an 8-bit-product
// instance see identical stimulus; each is compared against an arithmetic
// model of the multiply rules.
module tb_mul_datapath;
    logic clk;
    logic rst;

    mul_datapath_if #(.W(8), .PW(16)) if16 ();
    mul_datapath_if #(.W(8), .PW(8))  if8  ();

    mul_datapath #(.W(8), .PW(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    mul_datapath #(.W(8), .PW(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    int checks   = 0;
    int failures = 0;

    // model state: index 0 = PW16 instance, index 1 = PW8 instance
    int ma [2];
    int mb [2];
    int mp [2];
    int mo [2];
    int pmod [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ma[k] = 0; mb[k] = 0; mp[k] = 0; mo[k] = 0;
        end
    endtask

    task automatic step(input bit la, input bit lb, input bit cl,
                        input bit lp, input bit dc, input int d);
        int sum;
        @(negedge clk);
        if16.data_in = 8'(d); if8.data_in = 8'(d);
        if16.ld_a = la; if8.ld_a = la;
        if16.ld_b = lb; if8.ld_b = lb;
        if16.clr  = cl; if8.clr  = cl;
        if16.ld_p = lp; if8.ld_p = lp;
        if16.dec  = dc; if8.dec  = dc;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cl) begin
                mp[k] = 0; mo[k] = 0;
            end else if (lp && mb[k] != 0) begin
                sum = mp[k] + ma[k];
                if (sum >= pmod[k]) mo[k] = 1;
                mp[k] = sum % pmod[k];
            end
            if (lb) mb[k] = d;
            else if (dc && mb[k] != 0) mb[k] = mb[k] - 1;
            if (la) ma[k] = d;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // hold ld_p=dec=1 until eqz, returning the number of strobe cycles
    task automatic run_until_eqz(input int limit, output int n);
        n = 0;
        while (if16.eqz !== 1'b1 && n < limit) begin
            step(0, 0, 0, 1, 1, 0);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (if16.product !== 16'd0 || if16.eqz !== 1'b1 || if16.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: product=%0d eqz=%b ovf=%b required 0/1/0",
                     if16.product, if16.eqz, if16.ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle();
        checks++;
        if (if16.product !== 16'd0 || if16.eqz !== 1'b1 || if8.product !== 8'd0) begin
            failures++;
            $display("FAIL reset_release: product=%0d eqz=%b required 0/1",
                     if16.product, if16.eqz);
        end
    endtask

    task automatic test_normal();
        int n;
        step(1, 0, 0, 0, 0, 17);
        step(0, 1, 1, 0, 0, 5);
        run_until_eqz(20, n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL normal_eqz_latency: got %0d cycles required 5", n);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
        checks++;
        if (if16.product !== 16'd85 || if16.ovf !== 1'b0 || if16.eqz !== 1'b1) begin
            failures++;
            $display("FAIL normal_product: product=%0d ovf=%b eqz=%b required 85/0/1",
                     if16.product, if16.ovf, if16.eqz);
        end
    endtask

    task automatic test_zero();
        step(1, 1, 1, 0, 0, 9);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, 0);
            checks++;
            if (if16.eqz !== 1'b1 || if16.product !== 16'd0) begin
                failures++;
                $display("FAIL zero_mult cycle %0d: eqz=%b product=%0d required 1/0",
                         i, if16.eqz, if16.product);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        step(1, 0, 0, 0, 0, 200);
        step(0, 1, 1, 0, 0, 2);
        run_until_eqz(10, n);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if (if8.product !== 8'd144 || if8.ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pw8: product=%0d ovf=%b required 144/1",
                     if8.product, if8.ovf);
        end
        checks++;
        if (if16.product !== 16'd400 || if16.ovf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pw16: product=%0d ovf=%b required 400/0",
                     if16.product, if16.ovf);
        end
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (if8.product !== 8'd0 || if8.ovf !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: product=%0d ovf=%b required 0/0",
                     if8.product, if8.ovf);
        end
    endtask

    task automatic test_priority();
        int n;
        // ld_b beats dec: B becomes 7, observed as 7 strobes with A=1
        step(1, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 3);
        step(0, 1, 0, 0, 1, 7);
        run_until_eqz(20, n);
        checks++;
        if (n !== 7 || if16.product !== 16'd7) begin
            failures++;
            $display("FAIL prio_ldb_over_dec: cycles=%0d product=%0d required 7/7",
                     n, if16.product);
        end
        // clr beats ld_p with B non-zero
        step(1, 1, 1, 0, 0, 40);
        step(0, 1, 0, 1, 0, 1);
        checks++;
        if (if16.product !== 16'd40) begin
            failures++;
            $display("FAIL prio_setup: product=%0d required 40", if16.product);
        end
        step(0, 0, 1, 1, 0, 0);
        checks++;
        if (if16.product !== 16'd0) begin
            failures++;
            $display("FAIL prio_clr_over_ldp: product=%0d required 0", if16.product);
        end
        // ld_a and ld_b together: 6 x 6
        step(1, 1, 1, 0, 0, 6);
        run_until_eqz(20, n);
        checks++;
        if (n !== 6 || if16.product !== 16'd36) begin
            failures++;
            $display("FAIL prio_lda_ldb: cycles=%0d product=%0d required 6/36",
                     n, if16.product);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        step(1, 0, 0, 0, 0, 10);
        step(0, 1, 1, 0, 0, 8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
        checks++;
        if (if16.product !== 16'd30 || if16.eqz !== 1'b0) begin
            failures++;
            $display("FAIL mid_partial: product=%0d eqz=%b required 30/0",
                     if16.product, if16.eqz);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (if16.product !== 16'd0 || if16.ovf !== 1'b0 || if16.eqz !== 1'b1) begin
            failures++;
            $display("FAIL mid_async_reset: product=%0d ovf=%b eqz=%b required 0/0/1",
                     if16.product, if16.ovf, if16.eqz);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 3);
        step(0, 1, 1, 0, 0, 4);
        run_until_eqz(20, n);
        checks++;
        if (n !== 4 || if16.product !== 16'd12) begin
            failures++;
            $display("FAIL mid_after_reset: cycles=%0d product=%0d required 4/12",
                     n, if16.product);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        step(1, 0, 0, 0, 0, 6);
        step(0, 1, 1, 0, 0, 7);
        run_until_eqz(20, n);
        checks++;
        if (if16.product !== 16'd42) begin
            failures++;
            $display("FAIL b2b_first: product=%0d required 42", if16.product);
        end
        step(1, 0, 0, 0, 0, 11);
        step(0, 1, 1, 0, 0, 3);
        run_until_eqz(20, n);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if (n !== 3 || if16.product !== 16'd33) begin
            failures++;
            $display("FAIL b2b_second: cycles=%0d product=%0d required 3/33",
                     n, if16.product);
        end
    endtask

    task automatic test_random();
        bit la, lb, cl, lp, dc;
        int d;
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            la = ($urandom_range(0, 7) == 0);
            lb = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 24) == 0);
            lp = ($urandom_range(0, 3) != 0);
            dc = ($urandom_range(0, 3) != 0);
            d  = int'($urandom_range(0, 255));
            step(la, lb, cl, lp, dc, d);
            checks++;
            if (int'(if16.product) !== mp[0] || int'(if16.ovf) !== mo[0] ||
                int'(if16.eqz) !== int'(mb[0] == 0)) begin
                failures++;
                $display("FAIL random16 cycle %0d: product=%0d ovf=%b eqz=%b required %0d/%0d/%0d",
                         i, if16.product, if16.ovf, if16.eqz, mp[0], mo[0], int'(mb[0] == 0));
            end
            checks++;
            if (int'(if8.product) !== mp[1] || int'(if8.ovf) !== mo[1] ||
                int'(if8.eqz) !== int'(mb[1] == 0)) begin
                failures++;
                $display("FAIL random8 cycle %0d: product=%0d ovf=%b eqz=%b required %0d/%0d/%0d",
                         i, if8.product, if8.ovf, if8.eqz, mp[1], mo[1], int'(mb[1] == 0));
            end
        end
    endtask

    initial begin
        pmod[0] = 65536;
        pmod[1] = 256;
        model_reset();
        if16.data_in = '0; if16.ld_a = 0; if16.ld_b = 0; if16.clr = 0; if16.ld_p = 0; if16.dec = 0;
        if8.data_in  = '0; if8.ld_a  = 0; if8.ld_b  = 0; if8.clr  = 0; if8.ld_p  = 0; if8.dec  = 0;
        test_reset();
        test_normal();
        test_zero();
        test_overflow();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
